wb_host_arb: RTL

Two-master Wishbone arbiter in front of the `digital_core` internal Wishbone slave port. It shares the single downstream bus between the management SoC external port (`m0`) and the on-chip UART host bridge (`m1`). Arbitration is round-robin and grants are held for the whole cycle. An optional bus watchdog terminates stalled transfers with an error.

---
 rtl/wb_host_arb.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/wb_host_arb.sv
// wb_host_arb
// Two-master Wishbone arbiter in front of the digital_core internal slave port.
// m0 = management SoC external port, m1 = on-chip UART host bridge.
// Round-robin between the two masters; a grant is held for the whole cyc,
// so bursts and read-modify-write sequences stay atomic.
//
// Ports:
//   wb_clk_i, wb_rst_i    bus clock, async active-high reset
//   m0_*, m1_*            master-side Wishbone ports (cyc/stb/we/sel/adr/dat in,
//                         dat/ack/err out)
//   s_*                   slave-side Wishbone port
//   gnt_o                 one-hot current grant {m1, m0}; 00 = idle
//   tmo_o                 one-cycle pulse when the bus watchdog expires
//
// Optional feature: define WB_HOST_ARB_TMO_EN to build the bus watchdog. It
// terminates a transfer with err after 2^TMO_W - 1 stalled cycles. Without
// it, tmo_o is tied low and a stalled transfer waits forever.
//
// state | meaning
// IDLE  | no grant, slave cyc/stb held low
// GNT0  | m0 owns the slave port until m0_cyc_i falls
// GNT1  | m1 owns the slave port until m1_cyc_i falls

module wb_host_arb #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int TMO_W = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      gnt_o,
  output logic            tmo_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state, state_nxt;
  logic   last;
  logic   m0_req, m1_req;
  logic   fwd_stb;
  logic   tmo_fire;

  assign m0_req = m0_cyc_i & m0_stb_i;
  assign m1_req = m1_cyc_i & m1_stb_i;

  // Strobe of the granted master before any watchdog override; the watchdog
  // keys off this so the forced-low cycle cannot feed back into itself.
  assign fwd_stb = (state == GNT0) ? m0_stb_i :
                   (state == GNT1) ? m1_stb_i : 1'b0;

`ifdef WB_HOST_ARB_TMO_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             stall;

  assign stall = fwd_stb & ~s_ack_i & ~s_err_i;
  // A slave ack or err in the expiry cycle wins over the timeout.
  assign tmo_fire = stall & (tmo_cnt == {TMO_W{1'b1}});

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      tmo_cnt <= '0;
    else if (stall && !tmo_fire)
      tmo_cnt <= tmo_cnt + 1'b1;
    else
      tmo_cnt <= '0;
  end
`else
  // Watchdog compiled out: the count is a constant zero and never fires.
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_cnt  = '0;
  assign tmo_fire = (&tmo_cnt) & 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt == GNT0 && state != GNT0)
        last <= 1'b0;
      else if (state_nxt == GNT1 && state != GNT1)
        last <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = m0_we_i;
    s_sel_o   = m0_sel_i;
    s_adr_o   = m0_adr_i;
    s_dat_o   = m0_dat_i;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req && m1_req)
          state_nxt = last ? GNT0 : GNT1;
        else if (m0_req)
          state_nxt = GNT0;
        else if (m1_req)
          state_nxt = GNT1;
      end
      GNT0: begin
        s_cyc_o  = m0_cyc_i & ~tmo_fire;
        s_stb_o  = m0_stb_i & ~tmo_fire;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | tmo_fire;
        if (!m0_cyc_i || tmo_fire)
          state_nxt = IDLE;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i & ~tmo_fire;
        s_stb_o  = m1_stb_i & ~tmo_fire;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | tmo_fire;
        if (!m1_cyc_i || tmo_fire)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = {state == GNT1, state == GNT0};
  assign tmo_o    = tmo_fire;

endmodule
